// File: rtl/sprite_anim_render.sv
// Sprite renderer: hit test, ROM address generation, colour-key output stage and animation FSM.
// Optional SPRITE_SCALE2X_EN doubles the on-screen size of the sprite.
module sprite_anim_render #(
  parameter int          WIDTH           = 32,
  parameter int          HEIGHT          = 32,
  parameter int          FRAMES          = 4,
  parameter int          ADDR_W          = 16,
  parameter int          ROM_LAT         = 1,
  parameter int          TICKS_PER_FRAME = 6,
  parameter logic [15:0] TRANS_KEY       = 16'hffff
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic [9:0]        posx,
  input  logic [8:0]        posy,
  input  logic              enable,
  input  logic              flip_h,
  input  logic              frame_tick,
  input  logic              play,
  input  logic              oneshot,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [15:0]       color,
  output logic              is_display,
  output logic [3:0]        frame_idx,
  output logic              done
);

`ifdef SPRITE_SCALE2X_EN
  localparam int SCALE_SH = 1;
`else
  localparam int SCALE_SH = 0;
`endif

  localparam int          FRAME_SZ = WIDTH * HEIGHT;
  localparam logic [10:0] SPAN_X   = 11'(WIDTH << SCALE_SH);
  localparam logic [10:0] SPAN_Y   = 11'(HEIGHT << SCALE_SH);

  typedef enum logic [1:0] {ST_STOP, ST_PLAY, ST_DONE} state_t;

  state_t            state;
  logic [7:0]        tick_cnt;
  logic [ROM_LAT:0]  hit_pipe;

  logic [10:0]       x_ext, px_ext, y_ext, py_ext;
  logic [10:0]       dx, dy, col_raw, col, row;
  logic              in_range, hit;
  logic [ADDR_W-1:0] addr_next;

  // Widened arithmetic keeps posx+span from wrapping back onto column 0.
  always_comb begin
    x_ext    = {1'b0, x};
    px_ext   = {1'b0, posx};
    y_ext    = {2'b0, y};
    py_ext   = {2'b0, posy};
    dx       = x_ext - px_ext;
    dy       = y_ext - py_ext;
    in_range = (posx < 10'd640) && (posy < 9'd480);
    hit      = enable && in_range &&
               (x_ext >= px_ext) && (x_ext < px_ext + SPAN_X) &&
               (y_ext >= py_ext) && (y_ext < py_ext + SPAN_Y);
    col_raw  = dx >> SCALE_SH;
    row      = dy >> SCALE_SH;
    col      = flip_h ? (11'(WIDTH - 1) - col_raw) : col_raw;
    addr_next = ADDR_W'(frame_idx) * ADDR_W'(FRAME_SZ)
              + ADDR_W'(row) * ADDR_W'(WIDTH)
              + ADDR_W'(col);
  end

  // hit_pipe[ROM_LAT] lines up with rom_data for the address issued with that hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr   <= '0;
      hit_pipe   <= '0;
      color      <= TRANS_KEY;
      is_display <= 1'b0;
    end else begin
      if (hit)
        rom_addr <= addr_next;
      hit_pipe <= {hit_pipe[ROM_LAT-1:0], hit};
      if (hit_pipe[ROM_LAT] && (rom_data != TRANS_KEY)) begin
        color      <= rom_data;
        is_display <= 1'b1;
      end else begin
        color      <= TRANS_KEY;
        is_display <= 1'b0;
      end
    end
  end

  // Frames only advance on frame_tick, so a change never lands mid video frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_STOP;
      tick_cnt  <= '0;
      frame_idx <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_STOP: begin
          if (play) begin
            state    <= ST_PLAY;
            tick_cnt <= '0;
          end
        end
        ST_PLAY: begin
          if (!play) begin
            state <= ST_STOP;
          end else if (frame_tick) begin
            if (tick_cnt == 8'(TICKS_PER_FRAME - 1)) begin
              tick_cnt <= '0;
              if (frame_idx == 4'(FRAMES - 1)) begin
                if (oneshot) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
                end else begin
                  frame_idx <= '0;
                end
              end else begin
                frame_idx <= frame_idx + 4'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end
        ST_DONE: begin
          if (!play) begin
            state     <= ST_STOP;
            done      <= 1'b0;
            frame_idx <= '0;
          end
        end
        default: state <= ST_STOP;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_anim_render.sv
// Directed bench for sprite_anim_render: table-driven pixel vectors plus
// hand-written animation, edge and reset sequences.
module tb_sprite_anim_render;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x, posx;
  logic [8:0]  y, posy;
  logic        enable, flip_h, frame_tick, play, oneshot;
  logic [15:0] rom_addr, w_rom_addr;
  logic [15:0] rom_data = '0;
  logic [15:0] w_rom_data = '0;
  logic [15:0] color, w_color;
  logic        is_display, w_is_display;
  logic [3:0]  frame_idx, w_frame_idx;
  logic        done, w_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sprite_anim_render #(
    .WIDTH(4), .HEIGHT(4), .FRAMES(4), .ADDR_W(16), .ROM_LAT(1),
    .TICKS_PER_FRAME(2), .TRANS_KEY(16'hffff)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .posx(posx), .posy(posy),
    .enable(enable), .flip_h(flip_h), .frame_tick(frame_tick), .play(play),
    .oneshot(oneshot), .rom_addr(rom_addr), .rom_data(rom_data),
    .color(color), .is_display(is_display), .frame_idx(frame_idx), .done(done)
  );

  sprite_anim_render #(
    .WIDTH(32), .HEIGHT(32), .FRAMES(1), .ADDR_W(16), .ROM_LAT(1),
    .TICKS_PER_FRAME(2), .TRANS_KEY(16'hffff)
  ) dut_wide (
    .clk(clk), .rst(rst), .x(x), .y(y), .posx(posx), .posy(posy),
    .enable(enable), .flip_h(flip_h), .frame_tick(frame_tick), .play(play),
    .oneshot(oneshot), .rom_addr(w_rom_addr), .rom_data(w_rom_data),
    .color(w_color), .is_display(w_is_display), .frame_idx(w_frame_idx), .done(w_done)
  );

  // Synchronous ROMs with one clock of latency; word 2 is the transparent key.
  always_ff @(posedge clk) begin
    rom_data   <= (rom_addr == 16'd2) ? 16'hffff : rom_addr;
    w_rom_data <= w_rom_addr;
  end

  typedef struct {
    logic [9:0]  px;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        en;
    logic        flip;
    logic        exp_disp;
    logic [15:0] exp_color;
  } vec_t;

  vec_t vecs[$];
  vec_t edge_vecs[$];

  function automatic vec_t mk(input logic [9:0] px, input logic [9:0] vx, input logic [8:0] vy,
                              input logic en, input logic fl, input logic d, input logic [15:0] c);
    vec_t v;
    v.px = px; v.x = vx; v.y = vy; v.en = en; v.flip = fl; v.exp_disp = d; v.exp_color = c;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    posx   = v.px;
    x      = v.x;
    y      = v.y;
    enable = v.en;
    flip_h = v.flip;
  endtask

  task automatic tick_step(input int k, input logic [3:0] exp_frame, input logic exp_done);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check_output($sformatf("frame_idx tick %0d", k), 32'(frame_idx), 32'(exp_frame));
    check_output($sformatf("done tick %0d", k), 32'(done), 32'(exp_done));
    @(negedge clk);
    check_output($sformatf("rom_addr tick %0d", k), 32'(rom_addr), 32'(exp_frame) * 16);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] loop_exp[10] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd0, 4'd0, 4'd1};
  logic [3:0] shot_exp[8]  = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3};

  initial begin
    rst = 1'b1; x = '0; y = '0; posx = 10'd10; posy = 9'd5;
    enable = 1'b0; flip_h = 1'b0; frame_tick = 1'b0; play = 1'b0; oneshot = 1'b0;

    // Sprite at (10,5), 4x4; ROM word = address except word 2.
    for (int i = 9; i <= 15; i++)
      vecs.push_back(mk(10'd10, 10'(i), 9'd6, 1'b1, 1'b0, (i >= 10 && i <= 13),
                        (i >= 10 && i <= 13) ? 16'(i - 6) : 16'hffff));
    vecs.push_back(mk(10'd10, 10'd10, 9'd6, 1'b1, 1'b1, 1'b1, 16'd7));
    vecs.push_back(mk(10'd10, 10'd11, 9'd6, 1'b1, 1'b1, 1'b1, 16'd6));
    vecs.push_back(mk(10'd10, 10'd12, 9'd6, 1'b1, 1'b1, 1'b1, 16'd5));
    vecs.push_back(mk(10'd10, 10'd13, 9'd6, 1'b1, 1'b1, 1'b1, 16'd4));
    vecs.push_back(mk(10'd10, 10'd10, 9'd5, 1'b1, 1'b0, 1'b1, 16'd0));
    vecs.push_back(mk(10'd10, 10'd11, 9'd5, 1'b1, 1'b0, 1'b1, 16'd1));
    vecs.push_back(mk(10'd10, 10'd12, 9'd5, 1'b1, 1'b0, 1'b0, 16'hffff));
    vecs.push_back(mk(10'd10, 10'd13, 9'd5, 1'b1, 1'b0, 1'b1, 16'd3));
    vecs.push_back(mk(10'd10, 10'd11, 9'd4, 1'b1, 1'b0, 1'b0, 16'hffff));
    vecs.push_back(mk(10'd10, 10'd11, 9'd9, 1'b1, 1'b0, 1'b0, 16'hffff));
    vecs.push_back(mk(10'd10, 10'd13, 9'd8, 1'b1, 1'b0, 1'b1, 16'd15));
    vecs.push_back(mk(10'd10, 10'd11, 9'd6, 1'b0, 1'b0, 1'b0, 16'hffff));
    vecs.push_back(mk(10'd700, 10'd700, 9'd6, 1'b1, 1'b0, 1'b0, 16'hffff));
    vecs.push_back(mk(10'd10, 10'd12, 9'd7, 1'b1, 1'b0, 1'b1, 16'd10));

    // 32-wide sprite at column 630: only x=630..639 may hit, row 1 words are 32+col.
    for (int i = 626; i <= 639; i++)
      edge_vecs.push_back(mk(10'd630, 10'(i), 9'd6, 1'b1, 1'b0, (i >= 630),
                             (i >= 630) ? 16'(32 + i - 630) : 16'hffff));
    for (int i = 0; i <= 3; i++)
      edge_vecs.push_back(mk(10'd630, 10'(i), 9'd6, 1'b1, 1'b0, 1'b0, 16'hffff));
    for (int i = 20; i <= 22; i++)
      edge_vecs.push_back(mk(10'd630, 10'(i), 9'd6, 1'b1, 1'b0, 1'b0, 16'hffff));

    @(negedge clk);
    @(negedge clk);
    check_output("reset color", 32'(color), 32'hffff);
    check_output("reset is_display", 32'(is_display), 32'd0);
    check_output("reset rom_addr", 32'(rom_addr), 32'd0);
    check_output("reset frame_idx", 32'(frame_idx), 32'd0);
    check_output("reset done", 32'(done), 32'd0);
    rst = 1'b0;

    // One vector per clock; each result appears three clocks later.
    for (int i = 0; i < vecs.size() + 3; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        check_output($sformatf("vec %0d is_display", i - 3), 32'(is_display), 32'(vecs[i-3].exp_disp));
        check_output($sformatf("vec %0d color", i - 3), 32'(color), 32'(vecs[i-3].exp_color));
      end
      if (i < vecs.size())
        apply_stimulus(vecs[i]);
      else
        enable = 1'b0;
    end

    for (int i = 0; i < edge_vecs.size() + 3; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        check_output($sformatf("edge x=%0d is_display", edge_vecs[i-3].x), 32'(w_is_display),
                     32'(edge_vecs[i-3].exp_disp));
        check_output($sformatf("edge x=%0d color", edge_vecs[i-3].x), 32'(w_color),
                     32'(edge_vecs[i-3].exp_color));
      end
      if (i < edge_vecs.size())
        apply_stimulus(edge_vecs[i]);
      else
        enable = 1'b0;
    end

    // Looping animation: two ticks per step, four frames.
    do_reset();
    apply_stimulus(mk(10'd10, 10'd10, 9'd5, 1'b1, 1'b0, 1'b0, 16'd0));
    oneshot = 1'b0;
    play    = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 10; k++)
      tick_step(k, loop_exp[k], 1'b0);

    // Reset asserted between clock edges while an opaque pixel is showing.
    y = 9'd6;
    repeat (4) @(negedge clk);
    check_output("pre-reset is_display", 32'(is_display), 32'd1);
    check_output("pre-reset color", 32'(color), 32'd20);
    #2 rst = 1'b1;
    #1;
    check_output("async rst color", 32'(color), 32'hffff);
    check_output("async rst is_display", 32'(is_display), 32'd0);
    check_output("async rst frame_idx", 32'(frame_idx), 32'd0);
    @(negedge clk);
    play = 1'b0;
    rst  = 1'b0;
    @(negedge clk);
    check_output("post-rst +1 is_display", 32'(is_display), 32'd0);
    @(negedge clk);
    check_output("post-rst +2 is_display", 32'(is_display), 32'd0);
    @(negedge clk);
    check_output("post-rst +3 is_display", 32'(is_display), 32'd1);
    check_output("post-rst +3 color", 32'(color), 32'd4);

    // One-shot, with a tick coinciding with the STOP->PLAY transition that must be ignored.
    do_reset();
    y       = 9'd5;
    oneshot = 1'b1;
    @(negedge clk);
    play       = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check_output("oneshot start frame_idx", 32'(frame_idx), 32'd0);
    for (int k = 0; k < 8; k++)
      tick_step(k, shot_exp[k], (k == 7));
    tick_step(8, 4'd3, 1'b1);
    play = 1'b0;
    @(negedge clk);
    check_output("oneshot stop done", 32'(done), 32'd0);
    check_output("oneshot stop frame_idx", 32'(frame_idx), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_anim_render.md
Name: sprite_anim_render

Overview:
- Parametrised successor to the fixed-size title/sprite colour fetcher.
- Renders one WIDTH x HEIGHT sprite with FRAMES animation frames from an external synchronous ROM.
- Supports horizontal flip, colour-key transparency and an animation state machine driven by a per-video-frame tick.
- Sits between the VGA scan counters and the pixel mux; one instance per on-screen object (Mario, enemies, title).

Parameters:
- WIDTH, 32, sprite width in pixels (1..640)
- HEIGHT, 32, sprite height in pixels (1..480)
- FRAMES, 4, number of animation frames stored consecutively in ROM (1..16)
- ADDR_W, 16, ROM address width; must satisfy 2^ADDR_W >= FRAMES*WIDTH*HEIGHT
- ROM_LAT, 1, ROM read latency in clocks (1..3)
- TICKS_PER_FRAME, 6, frame_tick pulses per animation step (1..255)
- TRANS_KEY, 16'hffff, colour treated as transparent and output when not displaying

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  asynchronous active-high reset
- x  in  10  VGA scan column
- y  in  9  VGA scan row
- posx  in  10  sprite left-up corner column
- posy  in  9  sprite left-up corner row
- enable  in  1  sprite visible
- flip_h  in  1  mirror horizontally
- frame_tick  in  1  one-cycle pulse per video frame (vblank)
- play  in  1  level: request animation
- oneshot  in  1  1 = play once then stop on last frame; 0 = loop
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  16  ROM data, valid ROM_LAT clocks after rom_addr
- color  out  16  registered pixel colour
- is_display  out  1  registered opaque-pixel flag, aligned with color
- frame_idx  out  4  current animation frame
- done  out  1  one-shot finished

Behaviour:
- Reset values:
  - color = TRANS_KEY; is_display = 0; rom_addr = 0.
  - frame_idx = 0; done = 0; tick counter = 0; FSM = STOP.
  - Hit pipeline flags cleared.
- Hit test, computed with 11-bit column / 10-bit row arithmetic so posx+WIDTH never wraps:
  - hit = enable & x>=posx & x<posx+WIDTH & y>=posy & y<posy+HEIGHT.
  - posx >= 640 or posy >= 480 yields no hit and is not an error.
- Column and address:
  - col = flip_h ? WIDTH-1-(x-posx) : (x-posx); row = y-posy.
  - Address = frame_idx*WIDTH*HEIGHT + row*WIDTH + col, truncated to ADDR_W.
  - Address is registered into rom_addr on the next clk edge; when hit=0, rom_addr holds its last value.
- Pipeline:
  - hit is delayed through a (1+ROM_LAT)-deep shift register so it aligns with rom_data.
  - Output stage registers: if the delayed hit is set and rom_data != TRANS_KEY, then color <= rom_data and is_display <= 1. Otherwise color <= TRANS_KEY and is_display <= 0.
  - Total latency from x/y to color/is_display is ROM_LAT+2 clocks; throughput is one pixel per clock.
- Animation FSM, states STOP / PLAY / DONE:
  - STOP: frame_idx held. When play=1, go to PLAY and clear the tick counter.
  - PLAY: each frame_tick increments the tick counter. When it reaches TICKS_PER_FRAME-1 on a tick, the counter goes to 0 and the frame advances.
    - If frame_idx == FRAMES-1 and oneshot=0, frame_idx wraps to 0.
    - If frame_idx == FRAMES-1 and oneshot=1, hold frame_idx, set done=1, go to DONE.
    - Otherwise frame_idx increments.
    - When play drops to 0, go to STOP, keeping frame_idx.
  - DONE: done stays 1. When play=0, go to STOP, clear done and reset frame_idx to 0.
- Frame changes occur only on frame_tick cycles, so no mid-frame tearing.
- play and frame_tick in the same cycle while in STOP: the transition to PLAY is taken and the tick is not counted.
- FRAMES=1: PLAY never changes frame_idx; oneshot goes to DONE on the first completed step.
- rst asserted mid-line: all outputs return to reset values immediately; the first valid pixel appears ROM_LAT+2 clocks after release.

Optional Feature:
- Macro: SPRITE_SCALE2X_EN.
- Defined: the sprite is displayed at twice the size (2*WIDTH x 2*HEIGHT hit window).
  - col and row use (x-posx)>>1 and (y-posy)>>1.
  - Flip uses WIDTH-1-((x-posx)>>1).
  - Latency is unchanged.
- Undefined: 1:1 display as specified above.

Test Plan:
- Hit/latency: WIDTH=HEIGHT=4, FRAMES=1, ROM_LAT=1, posx=10, posy=5, rom_data=address, scan y=6, x=9..15:
  - is_display high only for outputs corresponding to x=10..13, 3 clocks after each x.
  - color = 4,5,6,7.
- Flip: same setup with flip_h=1, y=6, x=10..13 -> color 7,6,5,4.
- Transparency: ROM returns 16'hffff at (row 0, col 2) -> is_display=0 and color=16'hffff for that pixel; neighbouring pixels opaque.
- Loop animation: FRAMES=4, TICKS_PER_FRAME=2, play=1, oneshot=0, 10 frame_tick pulses -> frame_idx sequence 0,1,2,3,0,1; addresses offset by frame*16.
- One-shot: oneshot=1, same parameters -> frame_idx stops at 3 and done=1 on the 8th tick; play=0 -> STOP, done=0, frame_idx=0.
- Edge/reset:
  - posx=630, WIDTH=32 -> hits for x=630..639 only, no wrap to x=0..21.
  - Assert rst mid-sprite -> color=16'hffff, is_display=0 and frame_idx=0 asynchronously, before the next clk edge.
